// File: rtl/line_refill.sv
// line_refill: cache-line refill engine. Accepts one miss request, issues a
// 4-beat 32-bit read burst, assembles the beats into a 128-bit line and
// writes the whole line into the data array in a single cycle.
// Optional feature macro: REFILL_CRITICAL_WORD_FWD_EN (critical-word forward).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid, once raised by this block, stays high with its payload
// stable until accepted. Ready never depends on the partner's valid.
module line_refill #(
   parameter int INDEX_WIDTH = 4,
   parameter int LINE_BEATS  = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   req_valid,
   input  logic [31:0]            req_addr,
   output logic                   req_ready,
   output logic                   ar_valid,
   output logic [31:0]            ar_addr,
   output logic [3:0]             ar_len,
   input  logic                   ar_ready,
   input  logic                   r_valid,
   input  logic [31:0]            r_data,
   input  logic                   r_last,
   output logic                   r_ready,
   output logic [INDEX_WIDTH-1:0] bram_waddr,
   output logic [15:0]            bram_wen,
   output logic [127:0]           bram_wdata,
   output logic                   done,
   output logic                   busy,
   output logic                   err,
   output logic                   fwd_valid,
   output logic [31:0]            fwd_data,
   output logic [1:0]             state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      DATA  = 2'd2,
      WRITE = 2'd3
   } state_t;

   localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

   state_t       state_q, state_d;
   logic [31:4]  addr_q;
   logic [127:0] line_q;
   logic [1:0]   beat_cnt;
   logic         err_q;
   logic         beat_fire;

   assign beat_fire = (state_q == DATA) && r_valid;

   // State register; reset abandons any refill in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state and all FSM-decoded outputs.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      ar_valid  = 1'b0;
      ar_len    = 4'd0;
      r_ready   = 1'b0;
      bram_wen  = 16'h0000;
      done      = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_d = ADDR;
         end
         ADDR: begin
            ar_valid = 1'b1;
            ar_len   = 4'(LINE_BEATS - 1);
            if (ar_ready) state_d = DATA;
         end
         DATA: begin
            r_ready = 1'b1;
            if (r_valid && (beat_cnt == LAST_BEAT)) state_d = WRITE;
         end
         WRITE: begin
            bram_wen = 16'hFFFF;
            done     = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Latch the line-aligned miss address when a request is accepted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                        addr_q <= '0;
      else if (state_q == IDLE && req_valid) addr_q <= req_addr[31:4];
   end

   // Place each accepted beat into its word slot; word 0 is the low word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         line_q   <= '0;
         beat_cnt <= 2'd0;
      end else if (beat_fire) begin
         line_q[{beat_cnt, 5'd0} +: 32] <= r_data;
         beat_cnt                       <= beat_cnt + 2'd1;
      end
   end

   // Sticky flag: r_last disagreeing with our own beat count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                         err_q <= 1'b0;
      else if (beat_fire && (r_last != (beat_cnt == LAST_BEAT))) err_q <= 1'b1;
   end

   assign ar_addr    = {addr_q, 4'b0000};
   assign bram_waddr = addr_q[INDEX_WIDTH+3:4];
   assign bram_wdata = line_q;
   assign err        = err_q;
   assign state_dbg  = state_q;

`ifdef REFILL_CRITICAL_WORD_FWD_EN
   logic [1:0] word_q;

   // Remember which word of the line the miss actually asked for.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                        word_q <= 2'd0;
      else if (state_q == IDLE && req_valid) word_q <= req_addr[3:2];
   end

   assign fwd_valid = beat_fire && (beat_cnt == word_q);
   assign fwd_data  = fwd_valid ? r_data : 32'd0;
`else
   assign fwd_valid = 1'b0;
   assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_line_refill.sv
// tb_line_refill: directed bench for line_refill. Inputs are driven and
// outputs read on the falling clock edge; a monitor samples pulses shortly
// after each falling edge.
module tb_line_refill;

   logic         clk = 1'b0;
   logic         resetn;
   logic         req_valid;
   logic [31:0]  req_addr;
   logic         req_ready;
   logic         ar_valid;
   logic [31:0]  ar_addr;
   logic [3:0]   ar_len;
   logic         ar_ready;
   logic         r_valid;
   logic [31:0]  r_data;
   logic         r_last;
   logic         r_ready;
   logic [3:0]   bram_waddr;
   logic [15:0]  bram_wen;
   logic [127:0] bram_wdata;
   logic         done;
   logic         busy;
   logic         err;
   logic         fwd_valid;
   logic [31:0]  fwd_data;
   logic [1:0]   state_dbg;

   int errors = 0;
   int checks = 0;

   int           done_cnt = 0;
   int           wen_cnt  = 0;
   int           fwd_cnt  = 0;
   logic [127:0] cap_wdata;
   logic [3:0]   cap_waddr;
   logic [31:0]  fwd_cap;
   logic [31:0]  exp_q[$];

   // Clock
   always #5 clk = ~clk;

   line_refill #(.INDEX_WIDTH(4), .LINE_BEATS(4)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_len(ar_len), .ar_ready(ar_ready),
      .r_valid(r_valid), .r_data(r_data), .r_last(r_last), .r_ready(r_ready),
      .bram_waddr(bram_waddr), .bram_wen(bram_wen), .bram_wdata(bram_wdata),
      .done(done), .busy(busy), .err(err),
      .fwd_valid(fwd_valid), .fwd_data(fwd_data), .state_dbg(state_dbg)
   );

   // Monitor: count pulses and capture the written line.
   always @(negedge clk) begin
      #2;
      if (done) begin
         done_cnt++;
         cap_wdata = bram_wdata;
         cap_waddr = bram_waddr;
      end
      if (bram_wen != 16'h0000) wen_cnt++;
      if (fwd_valid) begin
         fwd_cnt++;
         fwd_cap = fwd_data;
      end
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver: present one request at the current falling edge.
   task automatic send_req(input logic [31:0] a);
      req_valid = 1'b1;
      req_addr  = a;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Driver: four beats base+0..base+3; r_last on beat last_idx; optional idle gap.
   task automatic send_beats(input logic [31:0] base, input int last_idx, input bit gap);
      int t;
      for (int i = 0; i < 4; i++) begin
         if (gap && i > 0) begin
            r_valid = 1'b0;
            @(negedge clk);
         end
         r_valid = 1'b1;
         r_data  = base + 32'(i);
         r_last  = (i == last_idx);
         t = 0;
         while (!r_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) begin
            checks++; errors++;
            $display("FAIL beat_wait: r_ready never rose for beat %0d", i);
         end
         @(negedge clk);
      end
      r_valid = 1'b0;
      r_last  = 1'b0;
   endtask

   // Driver: count falling edges until done is seen (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 100);
   endtask

   task automatic test_reset;
      resetn = 1'b0; req_valid = 1'b0; req_addr = '0; ar_ready = 1'b0;
      r_valid = 1'b0; r_data = '0; r_last = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: req_ready=%b busy=%b done=%b err=%b, required 1 0 0 0",
                  req_ready, busy, done, err);
      end
      checks++;
      if (ar_valid !== 1'b0 || ar_addr !== 32'h0 || ar_len !== 4'h0 || r_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_bus: ar_valid=%b ar_addr=%h ar_len=%h r_ready=%b, required all 0",
                  ar_valid, ar_addr, ar_len, r_ready);
      end
      checks++;
      if (bram_wen !== 16'h0 || bram_waddr !== 4'h0 || bram_wdata !== 128'h0 ||
          fwd_valid !== 1'b0 || fwd_data !== 32'h0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_bram: wen=%h waddr=%h wdata=%h fwd=%b/%h state=%0d, required all 0",
                  bram_wen, bram_waddr, bram_wdata, fwd_valid, fwd_data, state_dbg);
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero_wait;
      int lat;
      int d0;
      logic [31:0] w;
      d0 = done_cnt;
      ar_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL zw_req_ready: got %b, required 1", req_ready);
      end
      req_valid = 1'b1;
      req_addr  = 32'h0000_1234;
      fork
         begin
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if (ar_valid !== 1'b1 || ar_addr !== 32'h0000_1230 || ar_len !== 4'd3 || busy !== 1'b1) begin
               errors++;
               $display("FAIL zw_addr: ar_valid=%b ar_addr=%h ar_len=%0d busy=%b, required 1 00001230 3 1",
                        ar_valid, ar_addr, ar_len, busy);
            end
            send_beats(32'hA0, 3, 1'b0);
         end
         wait_done(lat);
      join
      // accept cycle through done cycle inclusive is 7 cycles
      checks++;
      if (lat !== 6) begin
         errors++;
         $display("FAIL zw_latency: done %0d edges after accept, required 6", lat);
      end
      checks++;
      if (done !== 1'b1 || bram_wen !== 16'hFFFF || bram_waddr !== 4'd3) begin
         errors++;
         $display("FAIL zw_write: done=%b wen=%h waddr=%0d, required 1 ffff 3", done, bram_wen, bram_waddr);
      end
      checks++;
      if (bram_wdata !== 128'h000000A3_000000A2_000000A1_000000A0) begin
         errors++;
         $display("FAIL zw_wdata: got %h, required 000000a3000000a2000000a1000000a0", bram_wdata);
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         w = exp_q.pop_front();
         checks++;
         if (cap_wdata[i*32 +: 32] !== w) begin
            errors++;
            $display("FAIL zw_word%0d: got %h, required %h", i, cap_wdata[i*32 +: 32], w);
         end
      end
      checks++;
      if (done !== 1'b0 || bram_wen !== 16'h0 || busy !== 1'b0 || req_ready !== 1'b1 || err !== 1'b0) begin
         errors++;
         $display("FAIL zw_idle: done=%b wen=%h busy=%b req_ready=%b err=%b, required 0 0 0 1 0",
                  done, bram_wen, busy, req_ready, err);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL zw_done_count: got %0d pulses, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_ar_wait;
      int lat;
      int bad;
      ar_ready = 1'b0;
      send_req(32'h0000_5678);
      // stray beat while waiting for the address handshake must be ignored
      r_valid = 1'b1; r_data = 32'hDEAD_BEEF; r_last = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (ar_valid !== 1'b1 || ar_addr !== 32'h0000_5670 || r_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL arw_hold: %0d of 5 cycles with ar_valid/ar_addr unstable or r_ready high", bad);
      end
      r_valid = 1'b0; r_last = 1'b0;
      ar_ready = 1'b1;
      checks++;
      if (ar_valid !== 1'b1 || ar_addr !== 32'h0000_5670) begin
         errors++;
         $display("FAIL arw_release: ar_valid=%b ar_addr=%h, required 1 00005670", ar_valid, ar_addr);
      end
      send_beats(32'hC0, 3, 1'b0);
      wait_done(lat);
      @(negedge clk);
      checks++;
      if (cap_wdata !== 128'h000000C3_000000C2_000000C1_000000C0 || cap_waddr !== 4'd7) begin
         errors++;
         $display("FAIL arw_line: waddr=%0d wdata=%h, required 7 000000c3000000c2000000c1000000c0",
                  cap_waddr, cap_wdata);
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL arw_err: got %b, required 0", err);
      end
   endtask

   task automatic test_busy_ignore;
      int d0;
      int bad;
      int lat;
      d0 = done_cnt;
      bad = 0;
      ar_ready = 1'b1;
      send_req(32'h0000_0020);
      fork
         send_beats(32'hD0, 3, 1'b0);
         begin
            for (int i = 0; i < 4; i++) begin
               req_valid = 1'b1;
               req_addr  = 32'hFFFF_FFF0;
               if (req_ready !== 1'b0) bad++;
               @(negedge clk);
            end
            req_valid = 1'b0;
         end
      join
      wait_done(lat);
      repeat (4) @(negedge clk);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL busy_req_ready: req_ready high in %0d busy cycles, required 0", bad);
      end
      checks++;
      if (done_cnt - d0 !== 1 || cap_waddr !== 4'd2) begin
         errors++;
         $display("FAIL busy_single_done: pulses=%0d waddr=%0d, required 1 2", done_cnt - d0, cap_waddr);
      end
      checks++;
      if (state_dbg !== 2'd0 || req_ready !== 1'b1 || ar_valid !== 1'b0) begin
         errors++;
         $display("FAIL busy_idle: state=%0d req_ready=%b ar_valid=%b, required 0 1 0",
                  state_dbg, req_ready, ar_valid);
      end
   endtask

   task automatic test_fwd;
      int f0;
      int lat;
      f0 = fwd_cnt;
      send_req(32'h0000_0048);
      send_beats(32'hB0, 3, 1'b1);
      wait_done(lat);
      @(negedge clk);
      checks++;
      if (cap_waddr !== 4'd4 || cap_wdata !== 128'h000000B3_000000B2_000000B1_000000B0) begin
         errors++;
         $display("FAIL fwd_line: waddr=%0d wdata=%h, required 4 000000b3000000b2000000b1000000b0",
                  cap_waddr, cap_wdata);
      end
`ifdef REFILL_CRITICAL_WORD_FWD_EN
      checks++;
      if (fwd_cnt - f0 !== 1 || fwd_cap !== 32'hB2) begin
         errors++;
         $display("FAIL fwd_pulse: pulses=%0d data=%h, required 1 000000b2", fwd_cnt - f0, fwd_cap);
      end
`else
      checks++;
      if (fwd_cnt - f0 !== 0) begin
         errors++;
         $display("FAIL fwd_off: pulses=%0d, required 0", fwd_cnt - f0);
      end
`endif
   endtask

   task automatic test_err;
      int lat;
      send_req(32'h0000_0040);
      send_beats(32'hE0, 2, 1'b1);
      checks++;
      if (done !== 1'b1 || bram_wdata !== 128'h000000E3_000000E2_000000E1_000000E0 || err !== 1'b1) begin
         errors++;
         $display("FAIL err_line: done=%b wdata=%h err=%b, required 1 000000e3000000e2000000e1000000e0 1",
                  done, bram_wdata, err);
      end
      @(negedge clk);
      send_req(32'h0000_0050);
      send_beats(32'hF0, 3, 1'b0);
      wait_done(lat);
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || cap_waddr !== 4'd5 || cap_wdata !== 128'h000000F3_000000F2_000000F1_000000F0) begin
         errors++;
         $display("FAIL err_sticky: err=%b waddr=%0d wdata=%h, required 1 5 000000f3000000f2000000f1000000f0",
                  err, cap_waddr, cap_wdata);
      end
   endtask

   task automatic test_reset_mid;
      int d0;
      int w0;
      send_req(32'h0000_3330);
      @(negedge clk);
      r_valid = 1'b1; r_data = 32'h1; r_last = 1'b0;
      @(negedge clk);
      r_data = 32'h2;
      @(negedge clk);
      r_valid = 1'b0;
      checks++;
      if (state_dbg !== 2'd2) begin
         errors++;
         $display("FAIL rstm_in_data: state=%0d, required 2", state_dbg);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if (state_dbg !== 2'd0 || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
          bram_wen !== 16'h0 || err !== 1'b0) begin
         errors++;
         $display("FAIL rstm_async: state=%0d req_ready=%b busy=%b done=%b wen=%h err=%b, required 0 1 0 0 0 0",
                  state_dbg, req_ready, busy, done, bram_wen, err);
      end
      d0 = done_cnt;
      w0 = wen_cnt;
      @(negedge clk);
      resetn = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (done_cnt !== d0 || wen_cnt !== w0 || req_ready !== 1'b1 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL rstm_discard: new done=%0d new wen=%0d req_ready=%b state=%0d, required 0 0 1 0",
                  done_cnt - d0, wen_cnt - w0, req_ready, state_dbg);
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_ar_wait();
      test_busy_ignore();
      test_fwd();
      test_err();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/line_refill.md
LINE_REFILL -- requirements
Module: line_refill

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 4, cache-line index width; matches data-array address width.
REQ-002 SHALL have parameter LINE_BEATS, fixed 4, 32-bit beats per 128-bit line; other values unsupported.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req_valid  input  1, req_addr  input  32, req_ready  output  1: miss request from cache.
REQ-006 SHALL have ports ar_valid  output  1, ar_addr  output  32, ar_len  output  4, ar_ready  input  1: bus burst address.
REQ-007 SHALL have ports r_valid  input  1, r_data  input  32, r_last  input  1, r_ready  output  1: bus read data.
REQ-008 SHALL have ports bram_waddr  output  INDEX_WIDTH, bram_wen  output  16, bram_wdata  output  128: data-array write port.
REQ-009 SHALL have ports done  output  1 (refill-complete pulse), busy  output  1, err  output  1 (sticky r_last mismatch).
REQ-010 SHALL have ports fwd_valid  output  1, fwd_data  output  32: critical-word forward (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, ADDR, DATA, WRITE.
REQ-012 IDLE: req_ready=1; req_valid&req_ready latches req_addr, -> ADDR next cycle.
REQ-013 ADDR: ar_valid=1, ar_addr={req_addr[31:4],4'b0}, ar_len=3; ar_valid held, ar_addr stable until ar_ready; ar_valid&ar_ready -> DATA.
REQ-014 DATA: r_ready=1; each r_valid&r_ready stores r_data into line word beat_cnt (word0 = bits 31:0), beat_cnt 2-bit, increments, wraps 3->0.
REQ-015 Fourth accepted beat -> WRITE; r_last ignored for sequencing.
REQ-016 r_last=1 on beat 0-2, or r_last=0 on beat 3, SHALL set err; err stays 1 until reset.
REQ-017 WRITE (exactly one cycle): bram_wen=16'hFFFF, bram_waddr=req_addr[INDEX_WIDTH+3:4], bram_wdata=assembled line; done=1; -> IDLE.
REQ-018 Outside WRITE bram_wen SHALL be 0; bram_waddr/bram_wdata don't-care but driven from registers.
REQ-019 busy=1 in ADDR, DATA, WRITE; 0 in IDLE.
REQ-020 Latency: req accept to done = 1 + ar wait + beat cycles + 1; with zero-wait bus = 7 cycles (accept edge to done cycle inclusive).
REQ-021 req_valid during busy SHALL be ignored (req_ready=0); no request queued.
REQ-022 r_valid outside DATA SHALL be ignored, r_ready=0.
REQ-023 done asserts the same cycle as bram_wen so the data array holds the line for a read the following cycle.

Reset
REQ-024 resetn=0 SHALL asynchronously force IDLE, beat_cnt=0, err=0, all outputs 0 except req_ready=1.
REQ-025 Reset in ADDR/DATA/WRITE SHALL discard the partial line; no BRAM write, no done after release.

Configuration
REQ-026 Macro REFILL_CRITICAL_WORD_FWD_EN defined: on the DATA beat where beat_cnt==req_addr[3:2], fwd_valid=1 and fwd_data=r_data combinationally in that cycle; exactly one pulse per refill.
REQ-027 Macro undefined: fwd_valid and fwd_data SHALL be constant 0; all other behaviour identical.

Verification
REQ-028 Zero-wait refill, req_addr=0x0000_1234, beats 0xA0..0xA3 with r_last on 4th -> ar_addr=0x0000_1230, ar_len=3, WRITE bram_waddr=3, bram_wdata=0x000000A3_000000A2_000000A1_000000A0, done 7 cycles after accept, err=0.
REQ-029 ar_ready held low 5 cycles -> ar_valid/ar_addr stable throughout, no r_ready until handshake.
REQ-030 r_valid toggling 1/0 on beats, r_last early on beat 2 -> line still written after 4th beat, err=1 and sticky.
REQ-031 req_valid pulses while busy -> ignored; single done; next req accepted only in IDLE.
REQ-032 resetn low after 2 beats -> state IDLE, bram_wen never asserted, done never asserted, req_ready=1.
REQ-033 FWD_EN defined, req_addr=0x0000_0048 -> fwd_valid on beat 2 only, fwd_data=beat-2 data; undefined -> fwd_valid stays 0.
